// File: rtl/pump_duty_decoder.sv
// Recovers the pump duty word by counting synchronised high samples over fixed windows.
// Also tracks loop lock across consecutive windows and flags a rail-stuck pump.
module pump_duty_decoder #(
  parameter int unsigned WINDOW     = 40000,
  parameter int unsigned LOCK_TOL   = 4,
  parameter int unsigned LOCK_COUNT = 8
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        enable,
  input  logic        pump_in,
  output logic [15:0] duty,
  output logic        duty_valid,
  output logic        locked,
  output logic        stuck
);

  typedef enum logic [1:0] {StUnlocked, StTracking, StLocked} lock_state_e;

  localparam logic [15:0] WinLast = 16'(WINDOW - 1);
  localparam logic [15:0] WinFull = 16'(WINDOW);
  localparam logic [16:0] Tol     = 17'(LOCK_TOL);
  localparam logic [7:0]  LockCnt = 8'(LOCK_COUNT);

  logic        s1_q, s2_q;
  logic [15:0] win_cnt_q, win_cnt_d;
  logic [15:0] ones_q, ones_d;
  logic [15:0] prev_q, prev_d;
  logic [7:0]  stable_q, stable_d;
  logic [15:0] duty_q, duty_d;
  logic        valid_q, valid_d;
  logic        stuck_q, stuck_d;
  logic        locked_q, locked_d;
  lock_state_e state_q, state_d;

  logic [15:0]        total;
  logic signed [16:0] diff;
  logic [16:0]        delta;
  logic [7:0]         stable_inc;
  logic               win_end;

  assign total      = ones_q + {15'd0, s2_q};
  assign diff       = $signed({1'b0, total}) - $signed({1'b0, prev_q});
  assign delta      = diff[16] ? 17'(-diff) : 17'(diff);
  assign stable_inc = stable_q + 8'd1;
  assign win_end    = enable && (win_cnt_q == WinLast);

  always_comb begin
    win_cnt_d = win_cnt_q;
    ones_d    = ones_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    duty_d    = duty_q;
    valid_d   = 1'b0;
    stuck_d   = stuck_q;
    locked_d  = locked_q;
    state_d   = state_q;

    if (!enable) begin
      // Abort: drop the partial window and all lock history, keep the last result.
      win_cnt_d = '0;
      ones_d    = '0;
      stable_d  = '0;
      locked_d  = 1'b0;
      state_d   = StUnlocked;
    end else if (win_end) begin
      duty_d    = total;
      valid_d   = 1'b1;
      stuck_d   = (total == 16'd0) || (total == WinFull);
      win_cnt_d = '0;
      ones_d    = '0;
      prev_d    = total;
      unique case (state_q)
        StUnlocked: begin
          stable_d = '0;
          locked_d = 1'b0;
          state_d  = StTracking;
        end
        StTracking: begin
          if (delta <= Tol) begin
            if (stable_inc >= LockCnt) begin
              stable_d = LockCnt;
              locked_d = 1'b1;
              state_d  = StLocked;
            end else begin
              stable_d = stable_inc;
            end
          end else begin
            stable_d = '0;
          end
        end
        StLocked: begin
          if (delta > Tol) begin
            stable_d = '0;
            locked_d = 1'b0;
            state_d  = StTracking;
          end
        end
        default: state_d = StUnlocked;
      endcase
    end else begin
      ones_d    = total;
      win_cnt_d = win_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      win_cnt_q <= '0;
      ones_q    <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      duty_q    <= '0;
      valid_q   <= 1'b0;
      stuck_q   <= 1'b0;
      locked_q  <= 1'b0;
      state_q   <= StUnlocked;
    end else begin
      s1_q      <= pump_in;
      s2_q      <= s1_q;
      win_cnt_q <= win_cnt_d;
      ones_q    <= ones_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      duty_q    <= duty_d;
      valid_q   <= valid_d;
      stuck_q   <= stuck_d;
      locked_q  <= locked_d;
      state_q   <= state_d;
    end
  end

  assign duty       = duty_q;
  assign duty_valid = valid_q;
  assign stuck      = stuck_q;
  assign locked     = locked_q;

endmodule

// File: tb/tb_pump_duty_decoder.sv
// Randomised bench for pump_duty_decoder against a window/duty-history reference model,
// plus a default-parameter instance for the full-length all-zero window.
module tb_pump_duty_decoder;

  localparam int unsigned W   = 20;
  localparam int unsigned TOL = 2;
  localparam int unsigned LC  = 3;
  localparam int unsigned WBIG = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        pump = 1'b0;
  logic [15:0] duty;
  logic        duty_valid, locked, stuck;

  logic        en_big = 1'b0;
  logic [15:0] duty_big;
  logic        valid_big, locked_big, stuck_big;

  always #5 clk = ~clk;

  pump_duty_decoder #(
    .WINDOW    (W),
    .LOCK_TOL  (TOL),
    .LOCK_COUNT(LC)
  ) u_dut (
    .clk_in    (clk),
    .reset_in  (rst),
    .enable    (en),
    .pump_in   (pump),
    .duty      (duty),
    .duty_valid(duty_valid),
    .locked    (locked),
    .stuck     (stuck)
  );

  pump_duty_decoder u_big (
    .clk_in    (clk),
    .reset_in  (rst),
    .enable    (en_big),
    .pump_in   (1'b0),
    .duty      (duty_big),
    .duty_valid(valid_big),
    .locked    (locked_big),
    .stuck     (stuck_big)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a window is just a list of samples; lock is the length of the
  // trailing run of stable window-to-window duty changes.
  bit s1_m, s2_m;
  int m_cnt, m_ones, m_prev, m_run, m_duty;
  bit m_have_prev, m_valid, m_stuck, m_locked;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s1_m = 0; s2_m = 0;
    m_cnt = 0; m_ones = 0; m_prev = 0; m_run = 0; m_duty = 0;
    m_have_prev = 0; m_valid = 0; m_stuck = 0; m_locked = 0;
  endtask

  task automatic model_edge(input bit e, input bit p);
    bit samp;
    int d;
    samp = s2_m;
    s2_m = s1_m;
    s1_m = p;
    m_valid = 0;
    if (!e) begin
      m_cnt = 0; m_ones = 0; m_have_prev = 0; m_run = 0; m_locked = 0;
    end else begin
      m_ones += int'(samp);
      m_cnt++;
      if (m_cnt == int'(W)) begin
        m_duty  = m_ones;
        m_valid = 1;
        m_stuck = (m_ones == 0) || (m_ones == int'(W));
        if (m_have_prev) begin
          d = m_ones - m_prev;
          if (d < 0) d = -d;
          m_run = (d <= int'(TOL)) ? m_run + 1 : 0;
        end
        m_have_prev = 1;
        m_prev   = m_ones;
        m_locked = (m_run >= int'(LC));
        m_cnt = 0;
        m_ones = 0;
      end
    end
  endtask

  task automatic check_all();
    check_eq("duty", 32'(duty), 32'(m_duty));
    check_eq("duty_valid", 32'(duty_valid), 32'(m_valid));
    check_eq("stuck", 32'(stuck), 32'(m_stuck));
    check_eq("locked", 32'(locked), 32'(m_locked));
  endtask

  // Called at a falling edge: drive inputs, take one rising edge, check at the next fall.
  task automatic cycle(input bit e, input bit p);
    en = e;
    pump = p;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(e, p);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int base, dw, drop;
    bit e;
    model_reset();
    #1 rst = 1'b1;
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomised windows of near-constant duty with occasional enable drops.
    base = 0;
    drop = 0;
    for (int win = 0; win < 150; win++) begin
      if (win % 6 == 0) base = $urandom_range(0, W);
      dw = base + (($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 2));
      if (dw > int'(W)) dw = W;
      for (int ph = 0; ph < int'(W); ph++) begin
        if (drop > 0) begin
          e = 0;
          drop--;
        end else begin
          e = 1;
          if ($urandom_range(0, 249) == 0) drop = $urandom_range(1, 12);
        end
        cycle(e, (ph < dw));
      end
    end

    // enable falls exactly on a window-end edge: no strobe, duty holds.
    while (m_cnt != int'(W) - 1) cycle(1, 1'($urandom_range(0, 1)));
    cycle(0, 1);
    for (int i = 0; i < 3 * int'(W); i++) cycle(1, 1);

    // Async reset mid-window with no clock edge; the prior window left duty=W, stuck=1.
    for (int i = 0; i < int'(W) / 2; i++) cycle(1, 1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    cycle(1, 1);
    rst = 1'b0;
    for (int i = 0; i < 10 * int'(W); i++) cycle(1, 1'($urandom_range(0, 3) != 0));

    // Full-length all-zero window on the default-parameter instance.
    en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    en_big = 1'b1;
    repeat (WBIG - 1) @(posedge clk);
    @(negedge clk);
    check_eq("big_valid_early", 32'(valid_big), 32'd0);
    check_eq("big_stuck_early", 32'(stuck_big), 32'd0);
    @(negedge clk);
    check_eq("big_duty", 32'(duty_big), 32'd0);
    check_eq("big_valid", 32'(valid_big), 32'd1);
    check_eq("big_stuck", 32'(stuck_big), 32'd1);
    check_eq("big_locked", 32'(locked_big), 32'd0);
    @(negedge clk);
    check_eq("big_valid_after", 32'(valid_big), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pump_duty_decoder.md
# pump_duty_decoder

Receive-side decoder for the VCXO loop-filter pump bitstream. It samples the 1-bit pump waveform in the PWM clock domain and counts high cycles over fixed windows to recover the duty word the controller is driving. It reports each result with a one-cycle strobe, and flags loop lock (consecutive stable windows) and a stuck pump (rail-to-rail duty). It sits between the pump pin loopback and the MCU telemetry registers.

## Interface
- WINDOW, 40000: window length in clocks; matches the pump frame length (1..65535).
- LOCK_TOL, 4: maximum |duty change| between consecutive windows that counts as stable.
- LOCK_COUNT, 8: consecutive stable windows required to assert locked (1..255).

- clk_in  input  1  PWM-domain clock; all logic on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- enable  input  1  high = measure; low = abort window, clear lock tracking.
- pump_in  input  1  pump bitstream; may be asynchronous, so it is synchronised internally.
- duty  output  16  ones count of last completed window (0..WINDOW).
- duty_valid  output  1  one-cycle strobe when duty updates.
- locked  output  1  loop-lock flag.
- stuck  output  1  last window was all-0 or all-1.

## Operation
- pump_in passes through a 2-FF synchroniser (s1, s2). Only s2 is counted.
- win_cnt: 16-bit, runs 0..WINDOW-1 while enable=1. ones: 16-bit accumulator of s2.
- Each enabled edge with win_cnt < WINDOW-1: ones += s2; win_cnt += 1.
- Edge with win_cnt == WINDOW-1 (window end), with total = ones + s2:
  - duty <= total.
  - duty_valid <= 1.
  - stuck <= (total == 0 || total == WINDOW).
  - ones <= 0; win_cnt <= 0.
- Lock FSM has three states, evaluated on each window end:
  - UNLOCKED (has_prev=0): store prev <= total and go to TRACKING; stable_cnt=0, locked=0.
  - TRACKING: delta = |total − prev|, computed as a 17-bit signed difference then absolute value. prev <= total.
    - If delta <= LOCK_TOL: stable_cnt += 1. When the increment reaches LOCK_COUNT, go to LOCKED and set locked <= 1 on the same edge.
    - Otherwise stable_cnt <= 0.
  - LOCKED: delta as above, prev <= total.
    - If delta > LOCK_TOL: locked <= 0, stable_cnt <= 0, go to TRACKING.
    - Otherwise stay; stable_cnt saturates at LOCK_COUNT.
- enable=0 on any edge:
  - win_cnt <= 0, ones <= 0; the partial window is discarded with no strobe.
  - FSM goes to UNLOCKED: locked <= 0, stable_cnt <= 0.
  - duty and stuck hold; duty_valid <= 0.
  - The synchroniser keeps running.
- enable rising: the next edge is sample 1 of a fresh full window.
- Arithmetic is unsigned 16-bit. WINDOW <= 65535 guarantees ones never wraps.

## Timing
- Reset values: duty=0, duty_valid=0, locked=0, stuck=0. Internally s1=s2=0, win_cnt=0, ones=0, stable_cnt=0, FSM=UNLOCKED. All take effect immediately on reset_in, with no clock needed.
- pump_in → s2 latency: 2 clk_in edges.
- With enable high from edge 0, samples are taken on edges 1..WINDOW. duty, duty_valid, stuck and locked all update on edge WINDOW, and duty_valid is high exactly until edge WINDOW+1.
- Subsequent strobes repeat every WINDOW edges. There is no dead cycle between windows.
- Minimum time to locked after enable: (LOCK_COUNT+1)·WINDOW edges.
- Reset deassertion mid-window: counting restarts from win_cnt=0 on the first edge with reset low and enable high.
- enable falling on the window-end edge: enable wins, so no strobe and no duty update.

## Test plan
- Constant high, WINDOW=100, pump_in=1 for ≥2 edges before enable → duty=100, stuck=1, duty_valid on edges 100, 200, 300, each one cycle wide.
- 25 % duty: 25 high / 75 low per 100, WINDOW=100 → duty=25 each window, stuck=0, locked=0 until window count allows.
- Lock, with LOCK_TOL=2, LOCK_COUNT=3, window duties 25, 26, 27, 27 → locked rises on the 4th window-end edge (edge 400). Then a window of 40 → locked=0 on that window-end edge; duty=40.
- Abort: enable low at edge 50 of a window, high again at edge 60 → no duty_valid in between; duty holds its old value; next strobe at edge 160; locked=0.
- Async reset: reset_in asserted mid-window with clk_in stopped → duty=0, duty_valid=0, locked=0, stuck=0 immediately.
- All zero, WINDOW=40000, pump_in=0 → duty=0, stuck=1 at edge 40000.
